dmem_lsu: RTL and testbench

- Load/store initiator that drives the data-memory port (10-bit word address, 32-bit write data, 4-bit byte enable, write enable, combinational read data) on behalf of the CPU datapath.
- Accepts one request at a time: lb/lbu/lh/lhu/lw/sb/sh/sw.
- Generates word address and byte enables; extracts and sign/zero-extends load data; flags misaligned, illegal-size and out-of-window accesses.
- Sits between the execute stage and the data memory. Used when the core moves to the multi-cycle/pipelined datapath.

---
 rtl/dmem_lsu.sv | 128 ++++++++++++
 tb/tb_dmem_lsu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP, driving a
// word-addressed data memory with big-endian byte lanes and sign/zero-extended loads.
module dmem_lsu #(
  parameter logic [31:0] DMEM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_be,
  output logic        mem_wren,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        we_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, rdata_q;

  logic        req_err;
  logic [3:0]  be_map;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  // Request rejection: illegal size, misalignment, or outside the 4 KB window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_addr[31:12] != DMEM_BASE[31:12]) req_err = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = req_err ? RESP : ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    be_map    = 4'b0000;
    byte_lane = 8'h00;
    half_lane = addr_q[1] ? mem_dout[15:0] : mem_dout[31:16];
    load_val  = mem_dout;
    case (addr_q[1:0])
      2'b00:   byte_lane = mem_dout[31:24];
      2'b01:   byte_lane = mem_dout[23:16];
      2'b10:   byte_lane = mem_dout[15:8];
      default: byte_lane = mem_dout[7:0];
    endcase
    case (size_q)
      2'b00: begin
        be_map   = 4'b1000 >> addr_q[1:0];
        load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
      end
      2'b01: begin
        be_map   = addr_q[1] ? 4'b0011 : 4'b1100;
        load_val = {{16{signed_q & half_lane[15]}}, half_lane};
      end
      2'b10:   be_map = 4'b1111;
      default: be_map = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 12'h000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr[11:0];
        wdata_q  <= req_wdata;
        err_q    <= req_err;
        rdata_q  <= 32'h0;
      end
      if (state == ACCESS && !we_q) rdata_q <= load_val;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q[11:2];
  assign mem_din    = wdata_q;
  assign mem_be     = (state == ACCESS) ? be_map : 4'b0000;
  // Gated by state only, so a store already in ACCESS completes even if rst is high.
  assign mem_wren   = (state == ACCESS) && we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: stimulus pushes expected responses and memory accesses,
// a negedge monitor pops and compares them against the DUT outputs cycle by cycle.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [3:0]  mem_be;
  logic        mem_wren;

  logic [31:0] tb_mem [1024];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic        wren;
    logic [31:0] din;
  } acc_t;

  resp_t rq[$];
  acc_t  aq[$];
  resp_t mr;
  acc_t  ma;

  dmem_lsu #(.DMEM_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_wren(mem_wren), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_dout = tb_mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of each queue.
  always @(negedge clk) begin
    if (!rst) begin
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_missing: no resp_valid at cycle %0d (now %0d)", rq[0].cyc, cyc);
        void'(rq.pop_front());
      end
      if (resp_valid) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          mr = rq.pop_front();
          check("resp_err", {31'b0, resp_err}, {31'b0, mr.err});
          check("resp_rdata", resp_rdata, mr.rdata);
        end else begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, required 0", cyc);
        end
      end
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        ma = aq.pop_front();
        check("mem_addr", {22'b0, mem_addr}, {22'b0, ma.addr});
        check("mem_be", {28'b0, mem_be}, {28'b0, ma.be});
        check("mem_wren", {31'b0, mem_wren}, {31'b0, ma.wren});
        check("mem_din", mem_din, ma.din);
      end else begin
        check("idle_be", {28'b0, mem_be}, 32'h0);
        check("idle_wren", {31'b0, mem_wren}, 32'h0);
      end
    end
  end

  // Issue one request and wait (bounded) for acceptance; returns the accept reference cycle.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata,
                      input logic [3:0] exp_be, input logic exp_resp,
                      input logic hold, output int t);
    bit ok = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    t = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %h not accepted within 10 cycles", addr);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (exp_resp) rq.push_back('{t + (exp_err ? 2 : 1) - (exp_err ? 1 : 0) + (exp_err ? 0 : 1), exp_err, exp_rdata});
      if (!exp_err) aq.push_back('{t + 1, addr[11:2], exp_be, we, wdata});
      #1;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  int t0, t1;

  initial begin
    foreach (tb_mem[i]) tb_mem[i] = 32'h0;
    tb_mem[4]    = 32'h80FF_7F01;
    tb_mem[1023] = 32'h1234_5678;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    check("rst_mem_be", {28'b0, mem_be}, 32'h0);
    check("rst_mem_wren", {31'b0, mem_wren}, 32'h0);
    rst = 1'b0;

    // Stores: we, size, signed, addr, wdata, err, rdata, be, resp, hold
    send(1, 2'b10, 0, 32'h10,  32'hDEAD_BEEF, 0, 32'h0, 4'b1111, 1, 0, t0);
    send(1, 2'b00, 0, 32'h13,  32'h0000_00AB, 0, 32'h0, 4'b0001, 1, 0, t0);
    send(1, 2'b01, 0, 32'h12,  32'h0000_1234, 0, 32'h0, 4'b0011, 1, 0, t0);
    send(1, 2'b00, 0, 32'h10,  32'h0000_00CD, 0, 32'h0, 4'b1000, 1, 0, t0);
    send(1, 2'b01, 0, 32'h10,  32'h0000_5678, 0, 32'h0, 4'b1100, 1, 0, t0);

    // Loads from word 4 = 0x80FF7F01
    send(0, 2'b00, 1, 32'h12,  32'h0, 0, 32'h0000_007F, 4'b0010, 1, 0, t0);
    send(0, 2'b00, 1, 32'h10,  32'h0, 0, 32'hFFFF_FF80, 4'b1000, 1, 0, t0);
    send(0, 2'b00, 0, 32'h10,  32'h0, 0, 32'h0000_0080, 4'b1000, 1, 0, t0);
    send(0, 2'b00, 1, 32'h11,  32'h0, 0, 32'hFFFF_FFFF, 4'b0100, 1, 0, t0);
    send(0, 2'b00, 0, 32'h13,  32'h0, 0, 32'h0000_0001, 4'b0001, 1, 0, t0);
    send(0, 2'b01, 1, 32'h10,  32'h0, 0, 32'hFFFF_80FF, 4'b1100, 1, 0, t0);
    send(0, 2'b01, 0, 32'h12,  32'h0, 0, 32'h0000_7F01, 4'b0011, 1, 0, t0);
    send(0, 2'b01, 1, 32'h12,  32'h0, 0, 32'h0000_7F01, 4'b0011, 1, 0, t0);
    send(0, 2'b10, 1, 32'h10,  32'h0, 0, 32'h80FF_7F01, 4'b1111, 1, 0, t0);
    send(0, 2'b10, 0, 32'hFFC, 32'h0, 0, 32'h1234_5678, 4'b1111, 1, 0, t0);

    // Rejected requests: one-cycle error response, no access
    send(0, 2'b10, 0, 32'h11,       32'h0,        1, 32'h0, 4'b0000, 1, 0, t0);
    send(1, 2'b01, 0, 32'h13,       32'h0000_BEEF, 1, 32'h0, 4'b0000, 1, 0, t0);
    send(1, 2'b11, 0, 32'h10,       32'h1111_1111, 1, 32'h0, 4'b0000, 1, 0, t0);
    send(1, 2'b10, 0, 32'h0000_2000, 32'hCAFE_F00D, 1, 32'h0, 4'b0000, 1, 0, t0);
    send(1, 2'b00, 0, 32'h0000_1003, 32'h0000_0077, 1, 32'h0, 4'b0000, 1, 0, t0);

    // req_valid held across a busy unit: next accept after 3 cycles (2 for an error)
    send(1, 2'b10, 0, 32'h20, 32'h0BAD_F00D, 0, 32'h0, 4'b1111, 1, 1, t0);
    send(0, 2'b10, 0, 32'h10, 32'h0,         0, 32'h80FF_7F01, 4'b1111, 1, 1, t1);
    check("accept_spacing_ok", t1 - t0, 3);
    send(0, 2'b10, 0, 32'h12, 32'h0,         1, 32'h0, 4'b0000, 1, 1, t0);
    send(0, 2'b00, 0, 32'h11, 32'h0,         0, 32'h0000_00FF, 4'b0100, 1, 0, t1);
    check("accept_spacing_err", t1 - t0, 2);

    // Reset during a load ACCESS: access happens, response is dropped
    send(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0, 4'b1111, 0, 0, t0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'h1);
    check("post_rst_resp_valid", {31'b0, resp_valid}, 32'h0);

    repeat (5) @(negedge clk);
    foreach (rq[i]) begin
      checks++; errors++;
      $display("FAIL resp_never_seen: expected at cycle %0d", rq[i].cyc);
    end
    foreach (aq[i]) begin
      checks++; errors++;
      $display("FAIL access_never_seen: expected at cycle %0d", aq[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
